sa_mm_engine: RTL and testbench



---
 rtl/attn_pkg.sv | 22 ++
 rtl/sa_mm_engine_if.sv | 28 ++
 rtl/sa_norm_sat.sv | 30 +++
 rtl/sa_mm_engine.sv | 124 ++++++++++++
 tb/tb_sa_mm_engine.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/attn_pkg.sv
// Shared definitions for the attention datapath: fixed-point format, engine FSM states and
// accumulator sizing.
package attn_pkg;

    localparam int unsigned FRAC_W = 5;

    // 1.0 in the signed 1.2.5 operand format
    localparam logic [7:0] ONE = 8'b0_01_00000;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_RUN  = 4'b0010,
        S_NORM = 4'b0100,
        S_DONE = 4'b1000
    } sa_state_e;

    // Wide enough that a full k-loop of worst-case products can never overflow
    function automatic int unsigned acc_w(input int unsigned d_w, input int unsigned m_dim);
        return 2 * d_w + $clog2(m_dim);
    endfunction

endpackage

// File: rtl/sa_mm_engine_if.sv
// Command interface between the attention controller (master) and the systolic engine (slave).
interface sa_mm_engine_if #(
    parameter int unsigned D_W   = 8,
    parameter int unsigned SA_R  = 16,
    parameter int unsigned SA_C  = 16,
    parameter int unsigned M_DIM = 16
);

    logic                                 I_SYNC_RSTN;
    logic                                 I_SA_START;
    logic [SA_R-1:0][M_DIM-1:0][D_W-1:0]  I_MAT_1;
    logic [M_DIM-1:0][SA_C-1:0][D_W-1:0]  I_MAT_2;
    logic                                 O_PE_SHIFT;
    logic                                 O_SA_VLD;
    logic                                 O_BUSY;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   O_SA_RESULT;

    modport master (
        output I_SYNC_RSTN, I_SA_START, I_MAT_1, I_MAT_2,
        input  O_PE_SHIFT, O_SA_VLD, O_BUSY, O_SA_RESULT
    );

    modport slave (
        input  I_SYNC_RSTN, I_SA_START, I_MAT_1, I_MAT_2,
        output O_PE_SHIFT, O_SA_VLD, O_BUSY, O_SA_RESULT
    );

endinterface

// File: rtl/sa_norm_sat.sv
// Converts one accumulator back to operand format: arithmetic shift by the fraction width,
// then clamp to the signed D_W range.
module sa_norm_sat #(
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned D_W    = 8,
    parameter int unsigned FRAC_W = 5
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [D_W-1:0]   res_o
);

    localparam int MAX_I = (1 << (D_W - 1)) - 1;
    localparam int MIN_I = -(1 << (D_W - 1));
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(MAX_I);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(MIN_I);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc_i >>> FRAC_W;
        if (shifted > MAX_V) begin
            res_o = MAX_V[D_W-1:0];
        end else if (shifted < MIN_V) begin
            res_o = MIN_V[D_W-1:0];
        end else begin
            res_o = shifted[D_W-1:0];
        end
    end

endmodule

// File: rtl/sa_mm_engine.sv
// Output-stationary matrix-multiply engine: latches both operands on start, adds one k-slice
// into every accumulator per cycle, then normalises and holds the saturated result.
module sa_mm_engine
    import attn_pkg::*;
#(
    parameter int unsigned D_W   = 8,
    parameter int unsigned SA_R  = 16,
    parameter int unsigned SA_C  = 16,
    parameter int unsigned M_DIM = 16
) (
    input logic           I_CLK,
    input logic           I_ASYN_RSTN,
    sa_mm_engine_if.slave sa_if
);

    localparam int unsigned AW = acc_w(D_W, M_DIM);
    localparam int unsigned KW = (M_DIM > 1) ? $clog2(M_DIM) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(M_DIM - 1);

    sa_state_e                            state_q, state_d;
    logic                                 load;
    logic [KW-1:0]                        k_q;
    logic [SA_R-1:0][M_DIM-1:0][D_W-1:0]  a_q;
    logic [M_DIM-1:0][SA_C-1:0][D_W-1:0]  b_q;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   res_q;
    logic signed [AW-1:0]                 acc_q    [SA_R][SA_C];
    logic [D_W-1:0]                       norm_res [SA_R][SA_C];

    function automatic logic signed [AW-1:0] mac(input logic signed [AW-1:0] acc,
                                                 input logic [D_W-1:0] a,
                                                 input logic [D_W-1:0] b);
        logic signed [2*D_W-1:0] p;
        p = (2 * D_W)'($signed(a)) * (2 * D_W)'($signed(b));
        return acc + AW'(p);
    endfunction

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        if (!sa_if.I_SYNC_RSTN) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (sa_if.I_SA_START) begin
                        state_d = S_RUN;
                        load    = 1'b1;
                    end
                end
                S_RUN:   if (k_q == K_LAST) state_d = S_NORM;
                S_NORM:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            k_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            for (int i = 0; i < SA_R; i++) begin
                for (int j = 0; j < SA_C; j++) acc_q[i][j] <= '0;
            end
        end else if (!sa_if.I_SYNC_RSTN) begin
            k_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            for (int i = 0; i < SA_R; i++) begin
                for (int j = 0; j < SA_C; j++) acc_q[i][j] <= '0;
            end
        end else begin
            if (load) begin
                k_q <= '0;
                a_q <= sa_if.I_MAT_1;
                b_q <= sa_if.I_MAT_2;
                for (int i = 0; i < SA_R; i++) begin
                    for (int j = 0; j < SA_C; j++) acc_q[i][j] <= '0;
                end
            end else if (state_q == S_RUN) begin
                k_q <= k_q + KW'(1);
                for (int i = 0; i < SA_R; i++) begin
                    for (int j = 0; j < SA_C; j++) begin
                        acc_q[i][j] <= mac(acc_q[i][j], a_q[i][k_q], b_q[k_q][j]);
                    end
                end
            end
            if (state_q == S_NORM) begin
                for (int i = 0; i < SA_R; i++) begin
                    for (int j = 0; j < SA_C; j++) res_q[i][j] <= norm_res[i][j];
                end
            end
        end
    end

    for (genvar gi = 0; gi < SA_R; gi++) begin : g_row
        for (genvar gj = 0; gj < SA_C; gj++) begin : g_col
            sa_norm_sat #(
                .ACC_W  (AW),
                .D_W    (D_W),
                .FRAC_W (FRAC_W)
            ) u_norm_sat (
                .acc_i (acc_q[gi][gj]),
                .res_o (norm_res[gi][gj])
            );
        end
    end

    assign sa_if.O_PE_SHIFT  = (state_q == S_RUN);
    assign sa_if.O_BUSY      = (state_q == S_RUN) || (state_q == S_NORM);
    assign sa_if.O_SA_VLD    = (state_q == S_DONE);
    assign sa_if.O_SA_RESULT = res_q;

endmodule

// File: tb/tb_sa_mm_engine.sv
// Directed bench for sa_mm_engine: latency, saturation, truncation, clear/restart handling.
module tb_sa_mm_engine;
    import attn_pkg::*;

    localparam int unsigned D_W   = 8;
    localparam int unsigned SA_R  = 16;
    localparam int unsigned SA_C  = 16;
    localparam int unsigned M_DIM = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sa_mm_engine_if #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .M_DIM(M_DIM)) sa_if ();

    sa_mm_engine #(
        .D_W   (D_W),
        .SA_R  (SA_R),
        .SA_C  (SA_C),
        .M_DIM (M_DIM)
    ) u_dut (
        .I_CLK       (clk),
        .I_ASYN_RSTN (rst_n),
        .sa_if       (sa_if)
    );

    task automatic check_vec(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int res(input int i, input int j);
        return int'($signed(sa_if.O_SA_RESULT[i][j]));
    endfunction

    // Reports the first element that differs from exp, or exp itself when all agree
    task automatic check_all(input string tag, input int exp);
        int got;
        got = exp;
        for (int i = 0; i < SA_R; i++) begin
            for (int j = 0; j < SA_C; j++) begin
                if (res(i, j) != exp && got == exp) got = res(i, j);
            end
        end
        check_vec(tag, got, exp);
    endtask

    task automatic load_mats(input int a, input int b, input bit b_ident);
        for (int i = 0; i < SA_R; i++) begin
            for (int k = 0; k < M_DIM; k++) sa_if.I_MAT_1[i][k] = 8'(a);
        end
        for (int k = 0; k < M_DIM; k++) begin
            for (int j = 0; j < SA_C; j++) begin
                sa_if.I_MAT_2[k][j] = (!b_ident || k == j) ? 8'(b) : 8'h00;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        sa_if.I_SA_START = 1'b1;
        @(negedge clk);
        sa_if.I_SA_START = 1'b0;
    endtask

    task automatic sync_clear();
        @(negedge clk);
        sa_if.I_SYNC_RSTN = 1'b0;
        @(negedge clk);
        sa_if.I_SYNC_RSTN = 1'b1;
    endtask

    // n counts edges since the start edge; bounded so a dead engine cannot hang the run
    task automatic wait_vld(input int n0, output int n);
        n = n0;
        while (!sa_if.O_SA_VLD && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int shift_cnt;
        int vld_edge;
        int vld_seen;

        sa_if.I_SYNC_RSTN = 1'b1;
        sa_if.I_SA_START  = 1'b0;
        load_mats(0, 0, 1'b0);
        repeat (2) @(negedge clk);
        check_vec("rst_vld", int'(sa_if.O_SA_VLD), 0);
        check_vec("rst_shift", int'(sa_if.O_PE_SHIFT), 0);
        check_vec("rst_busy", int'(sa_if.O_BUSY), 0);
        check_all("rst_result", 0);
        rst_n = 1'b1;

        // 1.0 x (0.25 * I): every entry 32*8 = 256 -> 8
        load_mats(int'(ONE), 8, 1'b1);
        pulse_start();
        shift_cnt = 0;
        vld_edge  = -1;
        for (int e = 0; e < 20; e++) begin
            if (sa_if.O_PE_SHIFT) shift_cnt++;
            if (sa_if.O_SA_VLD && vld_edge < 0) vld_edge = e;
            if (e == 3) check_vec("busy_run", int'(sa_if.O_BUSY), 1);
            if (e == 16) check_vec("busy_norm", int'(sa_if.O_BUSY), 1);
            if (e == 17) check_vec("busy_done", int'(sa_if.O_BUSY), 0);
            @(negedge clk);
        end
        check_vec("shift_cycles", shift_cnt, 16);
        check_vec("latency", vld_edge, 17);
        check_all("ident_result", 8);

        // 16 * 127 * 127 = 258064 -> 8064 -> clamp 127
        load_mats(127, 127, 1'b0);
        pulse_start();
        wait_vld(0, n);
        check_vec("pos_sat_latency", n, 17);
        check_all("pos_sat", 127);

        // Restart from DONE: 16 * -128 * 127 = -260096 -> -8128 -> clamp -128
        load_mats(-128, 127, 1'b0);
        pulse_start();
        check_vec("restart_vld_drop", int'(sa_if.O_SA_VLD), 0);
        wait_vld(0, n);
        check_vec("restart_latency", n, 17);
        check_all("neg_sat", -128);

        sync_clear();
        check_vec("clr_vld", int'(sa_if.O_SA_VLD), 0);
        check_all("clr_result", 0);

        // acc = 1 -> 1 >>> 5 = 0; acc = -1 -> -1 (toward -inf)
        load_mats(0, 0, 1'b0);
        sa_if.I_MAT_1[0][0] = 8'd1;
        sa_if.I_MAT_2[0][0] = 8'd1;
        pulse_start();
        wait_vld(0, n);
        check_vec("trunc_pos", res(0, 0), 0);
        check_all("trunc_pos_all", 0);
        sa_if.I_MAT_1[0][0] = 8'hFF;
        pulse_start();
        wait_vld(0, n);
        check_vec("trunc_neg", res(0, 0), -1);
        check_vec("trunc_neg_01", res(0, 1), 0);
        check_vec("trunc_neg_10", res(1, 0), 0);

        // Synchronous clear in the middle of RUN
        load_mats(int'(ONE), 8, 1'b1);
        pulse_start();
        repeat (4) @(negedge clk);
        sa_if.I_SYNC_RSTN = 1'b0;
        @(negedge clk);
        sa_if.I_SYNC_RSTN = 1'b1;
        check_vec("midclr_busy", int'(sa_if.O_BUSY), 0);
        check_vec("midclr_shift", int'(sa_if.O_PE_SHIFT), 0);
        check_vec("midclr_vld", int'(sa_if.O_SA_VLD), 0);
        check_all("midclr_result", 0);
        vld_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (sa_if.O_SA_VLD) vld_seen++;
        end
        check_vec("midclr_no_vld", vld_seen, 0);

        // Clear wins over a simultaneous start
        @(negedge clk);
        sa_if.I_SYNC_RSTN = 1'b0;
        sa_if.I_SA_START  = 1'b1;
        @(negedge clk);
        sa_if.I_SYNC_RSTN = 1'b1;
        sa_if.I_SA_START  = 1'b0;
        check_vec("clr_start_busy", int'(sa_if.O_BUSY), 0);
        check_vec("clr_start_shift", int'(sa_if.O_PE_SHIFT), 0);
        repeat (3) @(negedge clk);
        check_vec("clr_start_idle", int'(sa_if.O_BUSY), 0);

        // Second start during RUN is ignored even with new operands on the bus
        load_mats(int'(ONE), 8, 1'b1);
        pulse_start();
        repeat (2) @(negedge clk);
        load_mats(127, 127, 1'b0);
        sa_if.I_SA_START = 1'b1;
        @(negedge clk);
        sa_if.I_SA_START = 1'b0;
        wait_vld(3, n);
        check_vec("busy_start_latency", n, 17);
        check_all("busy_start_result", 8);

        // Asynchronous reset mid-run aborts without a clock edge
        load_mats(int'(ONE), 8, 1'b1);
        pulse_start();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_vec("arst_busy", int'(sa_if.O_BUSY), 0);
        check_vec("arst_shift", int'(sa_if.O_PE_SHIFT), 0);
        check_vec("arst_vld", int'(sa_if.O_SA_VLD), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_all("arst_result", 0);
        vld_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (sa_if.O_SA_VLD) vld_seen++;
        end
        check_vec("arst_no_vld", vld_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
